moo_seq: RTL and testbench



---
 rtl/moo_pkg.sv | 52 +++++
 rtl/moo_len_cnt.sv | 45 ++++
 rtl/moo_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_moo_seq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moo_pkg.sv
// Shared types and encodings for the ARIA mode-of-operation sequencer.
package moo_pkg;

  typedef enum logic [1:0] {
    MODE_ECB = 2'b00,
    MODE_CBC = 2'b01,
    MODE_CTR = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEXP,
    ST_LOAD,
    ST_WAIT_DI,
    ST_CIPH,
    ST_WAIT_CORE,
    ST_DO,
    ST_END
  } state_e;

  // ARIA core opcodes; key expansion carries the key size in the low bits.
  localparam logic [2:0] OP_KEXP = 3'b000;
  localparam logic [2:0] OP_ENC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b110;

  // Core input selection.
  localparam logic [1:0] BLK_DATA       = 2'b00;
  localparam logic [1:0] BLK_DATA_CHAIN = 2'b01;
  localparam logic [1:0] BLK_CTR        = 2'b10;

  // Output XOR selection.
  localparam logic [1:0] OX_NONE  = 2'b00;
  localparam logic [1:0] OX_CHAIN = 2'b01;
  localparam logic [1:0] OX_DATA  = 2'b10;

  // Chain register write source.
  localparam logic CS_CORE = 1'b0;
  localparam logic CS_DATA = 1'b1;

  // Error codes.
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_KEY   = 2'b01;
  localparam logic [1:0] ERR_WRAP  = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  // ECB has no chaining context, so it skips the IV load cycle.
  function automatic state_e first_state(input mode_e m);
    return (m == MODE_ECB) ? ST_WAIT_DI : ST_LOAD;
  endfunction

endpackage

// File: rtl/moo_len_cnt.sv
// Remaining-block down-counter with last-block flag and CTR wrap check.
module moo_len_cnt #(
  parameter int LEN_W = 16,
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             step,
  input  logic [LEN_W-1:0] len_in,
  input  logic [CTR_W-1:0] ctr_lo,
  output logic [LEN_W-1:0] rem,
  output logic             last,
  output logic             ctr_wrap
);

  // One extra bit over the wider operand so the sum cannot overflow.
  localparam int SUM_W = ((CTR_W > LEN_W) ? CTR_W : LEN_W) + 1;

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] limit;

  assign sum      = SUM_W'(ctr_lo) + SUM_W'(len_in);
  assign limit    = SUM_W'(1) << CTR_W;
  // Reaching exactly 2^CTR_W is fine: the last block uses counter 2^CTR_W-1.
  assign ctr_wrap = (sum > limit);
  assign last     = (rem == LEN_W'(1));

  // Remaining-block register: loaded on accept, decremented per delivered block.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
    end else if (clr) begin
      rem <= '0;
    end else if (load) begin
      rem <= len_in;
    end else if (step) begin
      rem <= rem - LEN_W'(1);
    end
  end

endmodule

// File: rtl/moo_seq.sv
// Multi-channel ARIA mode-of-operation sequencer: drives core and datapath strobes.
module moo_seq
  import moo_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int LEN_W = 16,
  parameter int CTR_W = 32,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_core,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [1:0]       cmd_mode,
  input  logic             cmd_dec,
  input  logic [CW-1:0]    cmd_ch,
  input  logic [1:0]       cmd_key_size,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [CTR_W-1:0] cmd_ctr_lo,
  input  logic             abort,
  output logic [2:0]       aria_op,
  output logic             aria_en,
  input  logic             r_ready,
  input  logic             k_ready,
  output logic [CW-1:0]    ch_sel,
  output logic             iv_ld,
  output logic             iv_upd,
  output logic [1:0]       blk_src,
  output logic [1:0]       out_xor,
  output logic             chain_we,
  output logic             chain_src,
  output logic             ctr_inc,
  output logic             di_ld,
  input  logic             moo_di_vld,
  output logic             moo_di_rdy,
  output logic             moo_do_vld,
  input  logic             moo_do_rdy,
  output logic             moo_do_lst,
  output logic             moo_done,
  output logic             moo_err,
  output logic [1:0]       err_code,
  output logic             moo_busy
);

  state_e           state_q, state_d;
  mode_e            mode_q;
  mode_e            cmd_mode_e;
  logic             dec_q;
  logic             len_nz_q;
  logic             accept, reject, abort_hit;
  logic [1:0]       rej_code;
  logic             cnt_step;
  logic [LEN_W-1:0] rem;
  logic             last, ctr_wrap;

  assign cmd_mode_e = mode_e'(cmd_mode);
  assign moo_busy   = (state_q != ST_IDLE);

  moo_len_cnt #(
    .LEN_W (LEN_W),
    .CTR_W (CTR_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_core | abort_hit),
    .load     (accept),
    .step     (cnt_step),
    .len_in   (cmd_len),
    .ctr_lo   (cmd_ctr_lo),
    .rem      (rem),
    .last     (last),
    .ctr_wrap (ctr_wrap)
  );

  // Next-state and all Mealy strobes; clr_core beats abort beats everything else.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cmd_rdy    = 1'b0;
    aria_op    = OP_KEXP;
    aria_en    = 1'b0;
    iv_ld      = 1'b0;
    iv_upd     = 1'b0;
    blk_src    = BLK_DATA;
    out_xor    = OX_NONE;
    chain_we   = 1'b0;
    chain_src  = CS_CORE;
    ctr_inc    = 1'b0;
    di_ld      = 1'b0;
    moo_di_rdy = 1'b0;
    moo_do_vld = 1'b0;
    moo_do_lst = 1'b0;
    moo_done   = 1'b0;
    moo_err    = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    rej_code   = ERR_NONE;
    abort_hit  = 1'b0;
    cnt_step   = 1'b0;

    if (clr_core) begin
      state_d = ST_IDLE;
    end else if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      abort_hit = 1'b1;
      moo_err   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_rdy = 1'b1;
          if (cmd_vld) begin
            if ((cmd_mode_e == MODE_RSV) || ((cmd_key_size == 2'd0) && !k_ready)) begin
              reject   = 1'b1;
              rej_code = ERR_KEY;
            end else if ((cmd_mode_e == MODE_CTR) && ctr_wrap) begin
              reject   = 1'b1;
              rej_code = ERR_WRAP;
            end else begin
              accept = 1'b1;
              if (cmd_len == '0) begin
                state_d = ST_END;
              end else if (cmd_key_size != 2'd0) begin
                aria_en = 1'b1;
                aria_op = OP_KEXP | {1'b0, cmd_key_size};
                state_d = ST_KEXP;
              end else begin
                state_d = first_state(cmd_mode_e);
              end
            end
            moo_err = reject;
          end
        end
        ST_KEXP: begin
          if (r_ready) state_d = first_state(mode_q);
        end
        ST_LOAD: begin
          iv_ld   = 1'b1;
          state_d = ST_WAIT_DI;
        end
        ST_WAIT_DI: begin
          moo_di_rdy = r_ready;
          if (moo_di_vld && r_ready) begin
            di_ld   = 1'b1;
            state_d = ST_CIPH;
          end
        end
        ST_CIPH: begin
          aria_en = 1'b1;
          case (mode_q)
            MODE_ECB: begin
              aria_op = dec_q ? OP_DEC : OP_ENC;
              blk_src = BLK_DATA;
            end
            MODE_CBC: begin
              aria_op = dec_q ? OP_DEC : OP_ENC;
              blk_src = dec_q ? BLK_DATA : BLK_DATA_CHAIN;
            end
            default: begin
              aria_op = OP_ENC;
              blk_src = BLK_CTR;
            end
          endcase
          state_d = ST_WAIT_CORE;
        end
        ST_WAIT_CORE: begin
          if (r_ready) state_d = ST_DO;
        end
        ST_DO: begin
          moo_do_vld = 1'b1;
          moo_do_lst = last;
          case (mode_q)
            MODE_CBC: out_xor = dec_q ? OX_CHAIN : OX_NONE;
            MODE_CTR: out_xor = OX_DATA;
            default:  out_xor = OX_NONE;
          endcase
          if (moo_do_rdy) begin
            cnt_step = 1'b1;
            if (mode_q == MODE_CBC) begin
              chain_we  = 1'b1;
              chain_src = dec_q ? CS_DATA : CS_CORE;
            end
            if (mode_q == MODE_CTR) ctr_inc = 1'b1;
            state_d = last ? ST_END : ST_WAIT_DI;
          end
        end
        ST_END: begin
          iv_upd   = (mode_q != MODE_ECB) && len_nz_q;
          moo_done = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Command context and sticky error code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_ECB;
      dec_q    <= 1'b0;
      len_nz_q <= 1'b0;
      ch_sel   <= '0;
      err_code <= ERR_NONE;
    end else begin
      if (cmd_vld && cmd_rdy) begin
        mode_q   <= cmd_mode_e;
        dec_q    <= cmd_dec;
        ch_sel   <= cmd_ch;
        len_nz_q <= (cmd_len != '0);
      end
      if (accept)         err_code <= ERR_NONE;
      else if (reject)    err_code <= rej_code;
      else if (abort_hit) err_code <= ERR_ABORT;
    end
  end

endmodule

// File: tb/tb_moo_seq.sv
// Self-checking bench for moo_seq: command vector table plus hand-written corner cases.
module tb_moo_seq;

  localparam int N_CH  = 4;
  localparam int LEN_W = 16;
  localparam int CTR_W = 8;
  localparam int L     = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr_core, cmd_vld, cmd_rdy, cmd_dec;
  logic [1:0]       cmd_mode, cmd_key_size;
  logic [1:0]       cmd_ch;
  logic [LEN_W-1:0] cmd_len;
  logic [CTR_W-1:0] cmd_ctr_lo;
  logic             abort;
  logic [2:0]       aria_op;
  logic             aria_en, r_ready, k_ready;
  logic [1:0]       ch_sel;
  logic             iv_ld, iv_upd;
  logic [1:0]       blk_src, out_xor;
  logic             chain_we, chain_src, ctr_inc, di_ld;
  logic             moo_di_vld, moo_di_rdy, moo_do_vld, moo_do_rdy, moo_do_lst;
  logic             moo_done, moo_err, moo_busy;
  logic [1:0]       err_code;

  always #5 clk = ~clk;

  moo_seq #(.N_CH(N_CH), .LEN_W(LEN_W), .CTR_W(CTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr_core(clr_core),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_mode(cmd_mode), .cmd_dec(cmd_dec),
    .cmd_ch(cmd_ch), .cmd_key_size(cmd_key_size), .cmd_len(cmd_len), .cmd_ctr_lo(cmd_ctr_lo),
    .abort(abort), .aria_op(aria_op), .aria_en(aria_en), .r_ready(r_ready), .k_ready(k_ready),
    .ch_sel(ch_sel), .iv_ld(iv_ld), .iv_upd(iv_upd), .blk_src(blk_src), .out_xor(out_xor),
    .chain_we(chain_we), .chain_src(chain_src), .ctr_inc(ctr_inc), .di_ld(di_ld),
    .moo_di_vld(moo_di_vld), .moo_di_rdy(moo_di_rdy), .moo_do_vld(moo_do_vld),
    .moo_do_rdy(moo_do_rdy), .moo_do_lst(moo_do_lst), .moo_done(moo_done),
    .moo_err(moo_err), .err_code(err_code), .moo_busy(moo_busy)
  );

  // Core model: busy for L cycles after every aria_en.
  logic [3:0] core_cnt;
  assign r_ready = (core_cnt == 4'd0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              core_cnt <= 4'd0;
    else if (aria_en)        core_cnt <= 4'(L);
    else if (core_cnt != 0)  core_cnt <= core_cnt - 4'd1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Current command as seen by the bench (drives expectations).
  logic [1:0] cur_mode;
  logic       cur_dec;
  logic [1:0] cur_ch;
  int         cur_len;

  // Event counters, sampled on the falling edge.
  int n_cmd, n_kexp, n_enc, n_dec, n_ivld, n_ivupd, n_cwe, n_cwe1, n_ctr;
  int n_done, n_err, n_out, n_ch_bad, blk_in;

  typedef struct packed {
    logic       lst;
    logic [1:0] ox;
  } sb_t;
  sb_t sb_q[$];

  function automatic logic [1:0] exp_blk();
    case (cur_mode)
      2'b01:   return cur_dec ? 2'b00 : 2'b01;
      2'b10:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] exp_ox();
    case (cur_mode)
      2'b01:   return cur_dec ? 2'b01 : 2'b00;
      2'b10:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic clear_counts();
    n_cmd = 0; n_kexp = 0; n_enc = 0; n_dec = 0; n_ivld = 0; n_ivupd = 0;
    n_cwe = 0; n_cwe1 = 0; n_ctr = 0; n_done = 0; n_err = 0; n_out = 0;
    n_ch_bad = 0; blk_in = 0;
    sb_q.delete();
  endtask

  // Monitor and scoreboard: push on input handshake, pop on output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_vld && cmd_rdy) n_cmd++;
      if (aria_en) begin
        if (!aria_op[2]) n_kexp++;
        else begin
          if (aria_op == 3'b110) n_dec++;
          else if (aria_op == 3'b100) n_enc++;
          check("blk_src", 32'(blk_src), 32'(exp_blk()));
        end
      end
      if (iv_ld)    n_ivld++;
      if (iv_upd)   n_ivupd++;
      if (chain_we) begin
        n_cwe++;
        if (chain_src) n_cwe1++;
      end
      if (ctr_inc)  n_ctr++;
      if (moo_done) n_done++;
      if (moo_err)  n_err++;
      if (moo_busy && (ch_sel != cur_ch)) n_ch_bad++;
      if (moo_di_vld && moo_di_rdy) begin
        sb_q.push_back('{lst: (blk_in == cur_len - 1), ox: exp_ox()});
        blk_in++;
      end
      if (moo_do_vld && moo_do_rdy) begin
        n_out++;
        if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          sb_t e;
          e = sb_q.pop_front();
          check("do_lst", 32'(moo_do_lst), 32'(e.lst));
          check("out_xor", 32'(out_xor), 32'(e.ox));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [1:0] mode, input logic dec, input logic [1:0] ch,
                           input logic [1:0] ks, input int len, input logic [7:0] ctr);
    cur_mode = mode; cur_dec = dec; cur_ch = ch; cur_len = len;
    cmd_mode = mode; cmd_dec = dec; cmd_ch = ch; cmd_key_size = ks;
    cmd_len = LEN_W'(len); cmd_ctr_lo = ctr; cmd_vld = 1'b1;
  endtask

  // Issue a command, wait for its handshake, then for moo_done or moo_err.
  task automatic run_cmd(input logic [1:0] mode, input logic dec, input logic [1:0] ch,
                         input logic [1:0] ks, input int len, input logic [7:0] ctr);
    int n;
    clear_counts();
    drive_cmd(mode, dec, ch, ks, len, ctr);
    for (n = 0; n < 50 && n_cmd == 0; n++) tick();
    cmd_vld = 1'b0;
    if (n_cmd == 0) check("cmd_handshake_timeout", 32'd0, 32'd1);
    for (n = 0; n < 1000 && (n_done + n_err) == 0; n++) tick();
    if ((n_done + n_err) == 0) check("completion_timeout", 32'd0, 32'd1);
    tick(); tick();
  endtask

  typedef struct {
    logic [1:0] mode; logic dec; logic [1:0] ch; logic [1:0] ks; int len; logic [7:0] ctr;
    logic krdy;
    int e_err; int e_code; int e_kexp; int e_enc; int e_dec; int e_ivld; int e_ivupd;
    int e_cwe; int e_cwe1; int e_ctr; int e_done;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;

    //          mode  dec  ch  ks  len ctr    krdy err code kexp enc dec ivld ivupd cwe cwe1 ctr done
    vecs[0] = '{2'b00, 0, 2'd0, 2'd1, 3, 8'h00, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1}; // ECB enc, kexp
    vecs[1] = '{2'b01, 1, 2'd2, 2'd0, 2, 8'h00, 1, 0, 0, 0, 0, 2, 1, 1, 2, 2, 0, 1}; // CBC dec
    vecs[2] = '{2'b10, 0, 2'd1, 2'd0, 2, 8'hFE, 1, 0, 0, 0, 2, 0, 1, 1, 0, 0, 2, 1}; // CTR at limit
    vecs[3] = '{2'b10, 0, 2'd1, 2'd0, 3, 8'hFE, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // CTR wrap
    vecs[4] = '{2'b00, 0, 2'd0, 2'd0, 1, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // no key
    vecs[5] = '{2'b11, 0, 2'd0, 2'd1, 1, 8'h00, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // bad mode
    vecs[6] = '{2'b01, 0, 2'd3, 2'd0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}; // len 0
    vecs[7] = '{2'b01, 0, 2'd1, 2'd2, 2, 8'h00, 1, 0, 0, 1, 2, 0, 1, 1, 2, 0, 0, 1}; // CBC enc
    vecs[8] = '{2'b00, 1, 2'd3, 2'd0, 1, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1}; // ECB dec
    vecs[9] = '{2'b10, 1, 2'd2, 2'd3, 1, 8'h00, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 1}; // CTR dec ignored

    rst_n = 1'b0; clr_core = 1'b0; cmd_vld = 1'b0; cmd_mode = 2'b00; cmd_dec = 1'b0;
    cmd_ch = 2'd0; cmd_key_size = 2'd0; cmd_len = '0; cmd_ctr_lo = '0; abort = 1'b0;
    k_ready = 1'b0; moo_di_vld = 1'b0; moo_do_rdy = 1'b0;
    cur_mode = 2'b00; cur_dec = 1'b0; cur_ch = 2'd0; cur_len = 0;
    clear_counts();

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("rst_busy", 32'(moo_busy), 32'd0);
    check("rst_ch_sel", 32'(ch_sel), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_strobes", 32'({aria_en, iv_ld, iv_upd, chain_we, ctr_inc, di_ld, moo_do_vld,
                             moo_done, moo_err}), 32'd0);
    tick();
    rst_n = 1'b1;
    moo_di_vld = 1'b1;
    moo_do_rdy = 1'b1;
    tick();

    // Table-driven commands.
    for (int i = 0; i < 10; i++) begin
      k_ready = vecs[i].krdy;
      run_cmd(vecs[i].mode, vecs[i].dec, vecs[i].ch, vecs[i].ks, vecs[i].len, vecs[i].ctr);
      check($sformatf("v%0d_err", i),      32'(n_err),    32'(vecs[i].e_err));
      check($sformatf("v%0d_code", i),     32'(err_code), 32'(vecs[i].e_code));
      check($sformatf("v%0d_kexp", i),     32'(n_kexp),   32'(vecs[i].e_kexp));
      check($sformatf("v%0d_enc", i),      32'(n_enc),    32'(vecs[i].e_enc));
      check($sformatf("v%0d_dec", i),      32'(n_dec),    32'(vecs[i].e_dec));
      check($sformatf("v%0d_iv_ld", i),    32'(n_ivld),   32'(vecs[i].e_ivld));
      check($sformatf("v%0d_iv_upd", i),   32'(n_ivupd),  32'(vecs[i].e_ivupd));
      check($sformatf("v%0d_chain_we", i), 32'(n_cwe),    32'(vecs[i].e_cwe));
      check($sformatf("v%0d_chain_s1", i), 32'(n_cwe1),   32'(vecs[i].e_cwe1));
      check($sformatf("v%0d_ctr_inc", i),  32'(n_ctr),    32'(vecs[i].e_ctr));
      check($sformatf("v%0d_done", i),     32'(n_done),   32'(vecs[i].e_done));
      check($sformatf("v%0d_outs", i),     32'(n_out),
            32'(vecs[i].e_done != 0 ? vecs[i].len : 0));
      check($sformatf("v%0d_ch_sel", i),   32'(n_ch_bad), 32'd0);
      check($sformatf("v%0d_sb_left", i),  32'(sb_q.size()), 32'd0);
    end
    k_ready = 1'b1;

    // Backpressure: output held for 5 cycles, then both blocks drain.
    clear_counts();
    moo_do_rdy = 1'b0;
    drive_cmd(2'b00, 1'b0, 2'd1, 2'd0, 2, 8'h00);
    for (n = 0; n < 50 && n_cmd == 0; n++) tick();
    cmd_vld = 1'b0;
    for (n = 0; n < 100 && !moo_do_vld; n++) tick();
    check("bp_do_vld_seen", 32'(moo_do_vld), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_do_vld_held", 32'({moo_do_vld, moo_do_lst, out_xor}), 32'b1000);
      tick();
    end
    check("bp_no_out", 32'(n_out), 32'd0);
    moo_do_rdy = 1'b1;
    tick();
    check("bp_one_out", 32'(n_out), 32'd1);
    check("bp_back_waiting", 32'(moo_do_vld), 32'd0);
    for (n = 0; n < 200 && n_done == 0; n++) tick();
    check("bp_outs", 32'(n_out), 32'd2);
    check("bp_done", 32'(n_done), 32'd1);
    tick();

    // Abort during WAIT_CORE of block 2 of 4 (CBC enc would otherwise write back IV).
    clear_counts();
    drive_cmd(2'b01, 1'b0, 2'd3, 2'd0, 4, 8'h00);
    for (n = 0; n < 50 && n_cmd == 0; n++) tick();
    cmd_vld = 1'b0;
    for (n = 0; n < 200 && n_enc < 2; n++) tick();
    check("ab_reached_blk2", 32'(n_enc), 32'd2);
    abort = 1'b1;
    @(negedge clk);
    check("ab_err_pulse", 32'({moo_err, aria_en, iv_upd, moo_done}), 32'b1000);
    tick();
    abort = 1'b0;
    check("ab_idle", 32'(moo_busy), 32'd0);
    check("ab_code", 32'(err_code), 32'd3);
    repeat (10) tick();
    check("ab_no_iv_upd", 32'(n_ivupd), 32'd0);
    check("ab_no_done", 32'(n_done), 32'd0);
    check("ab_outs", 32'(n_out), 32'd1);

    // len = 0 back-to-back: done one cycle after accept; cmd_vld during END waits.
    clear_counts();
    drive_cmd(2'b00, 1'b0, 2'd2, 2'd0, 0, 8'h00);
    @(negedge clk);
    check("l0_accept", 32'(cmd_rdy), 32'd1);
    @(negedge clk);
    check("l0_done_rdy", 32'({moo_done, cmd_rdy, moo_busy}), 32'b101);
    @(negedge clk);
    check("l0_reaccept", 32'({moo_done, cmd_rdy}), 32'b01);
    tick();
    cmd_vld = 1'b0;
    @(negedge clk);
    check("l0_done2", 32'(moo_done), 32'd1);
    tick(); tick();
    check("l0_no_data", 32'(n_out + blk_in + n_enc + n_dec), 32'd0);
    check("l0_done_cnt", 32'(n_done), 32'd2);

    // Asynchronous reset mid-command.
    clear_counts();
    drive_cmd(2'b01, 1'b0, 2'd1, 2'd1, 3, 8'h00);
    for (n = 0; n < 50 && n_cmd == 0; n++) tick();
    cmd_vld = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outputs", 32'({moo_busy, ch_sel, aria_en, moo_do_vld, iv_ld}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
